// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared float format defaults and accumulator state type
package float_pkg;

  localparam int FLOAT_EXP_WIDTH = 8;
  localparam int FLOAT_SFD_WIDTH = 23;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

endpackage

// File: rtl/float_adder_norm.sv
// rtl/float_adder_norm.sv - combinational float add, round-to-nearest-even, subnormals flushed
module float_adder_norm
  import float_pkg::*;
#(
  parameter int EXP_WIDTH = FLOAT_EXP_WIDTH,
  parameter int SFD_WIDTH = FLOAT_SFD_WIDTH
) (
  input  logic [EXP_WIDTH+SFD_WIDTH:0] a,
  input  logic [EXP_WIDTH+SFD_WIDTH:0] b,
  output logic [EXP_WIDTH+SFD_WIDTH:0] sum
);

  localparam int MW   = SFD_WIDTH + 1;
  localparam int W    = MW + 3;
  localparam int EMAX = (1 << EXP_WIDTH) - 1;
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

  logic                 sa, sb;
  logic [EXP_WIDTH-1:0] ea, eb;
  logic [SFD_WIDTH-1:0] fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);

  logic                         a_big, sl, ss, rnd_up;
  logic [EXP_WIDTH-1:0]         el, es;
  logic [MW-1:0]                ml, ms;
  logic [2*W-1:0]               pair;
  logic [W-1:0]                 small_sh, norm;
  logic [W:0]                   raw;
  logic [MW:0]                  rounded;
  logic [SFD_WIDTH-1:0]         frac;
  logic [EXP_WIDTH+SFD_WIDTH:0] norm_res;
  int                           shamt, msb, exp_n;

  // Operands carry guard/round/sticky bits; the smaller one is aligned with sticky folded into bit 0.
  always_comb begin
    a_big = ({ea, fa} >= {eb, fb});
    sl    = a_big ? sa : sb;
    ss    = a_big ? sb : sa;
    el    = a_big ? ea : eb;
    es    = a_big ? eb : ea;
    ml    = a_big ? {1'b1, fa} : {1'b1, fb};
    ms    = a_big ? {1'b1, fb} : {1'b1, fa};

    shamt = int'(el - es);
    if (shamt > W) shamt = W;
    pair     = {ms, 3'b000, {W{1'b0}}} >> shamt;
    small_sh = pair[2*W-1:W] | {{(W-1){1'b0}}, |pair[W-1:0]};

    if (sl == ss) raw = {1'b0, ml, 3'b000} + {1'b0, small_sh};
    else          raw = {1'b0, ml, 3'b000} - {1'b0, small_sh};

    msb = 0;
    for (int i = 0; i <= W; i++) begin
      if (raw[i]) msb = i;
    end

    if (raw[W]) begin
      norm  = raw[W:1] | {{(W-1){1'b0}}, raw[0]};
      exp_n = int'(el) + 1;
    end else begin
      norm  = raw[W-1:0] << (W - 1 - msb);
      exp_n = int'(el) - (W - 1 - msb);
    end

    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded = {1'b0, norm[W-1:3]} + {{MW{1'b0}}, rnd_up};
    if (rounded[MW]) exp_n = exp_n + 1;
    frac = rounded[MW] ? rounded[SFD_WIDTH:1] : rounded[SFD_WIDTH-1:0];

    if (raw == '0)          norm_res = '0;
    else if (exp_n >= EMAX) norm_res = {sl, EXP_ONES, {SFD_WIDTH{1'b0}}};
    else if (exp_n <= 0)    norm_res = {sl, {(EXP_WIDTH+SFD_WIDTH){1'b0}}};
    else                    norm_res = {sl, EXP_WIDTH'(exp_n), frac};
  end

  always_comb begin
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      sum = {1'b0, EXP_ONES, {{(SFD_WIDTH-1){1'b0}}, 1'b1}};
    else if (a_inf)             sum = a;
    else if (b_inf)             sum = b;
    else if (a_zero && b_zero)  sum = {sa & sb, {(EXP_WIDTH+SFD_WIDTH){1'b0}}};
    else if (a_zero)            sum = b;
    else if (b_zero)            sum = a;
    else                        sum = norm_res;
  end

endmodule

// File: rtl/float_accumulator.sv
// rtl/float_accumulator.sv - streaming float vector summer with one-deep result hold
module float_accumulator
  import float_pkg::*;
#(
  parameter int EXP_WIDTH = FLOAT_EXP_WIDTH,
  parameter int SFD_WIDTH = FLOAT_SFD_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_WIDTH+SFD_WIDTH:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_WIDTH+SFD_WIDTH:0] out_data,
  output logic [CNT_WIDTH-1:0]         out_count
);

  acc_state_t                   state, next_state;
  logic [EXP_WIDTH+SFD_WIDTH:0] acc, sum;
  logic [CNT_WIDTH-1:0]         count, count_inc;
  logic                         in_fire;

  float_adder_norm #(
    .EXP_WIDTH(EXP_WIDTH),
    .SFD_WIDTH(SFD_WIDTH)
  ) u_add (
    .a  (acc),
    .b  (in_data),
    .sum(sum)
  );

  // A pending result only blocks input when the consumer is stalled.
  assign in_ready  = (state == ACC) || out_ready;
  assign out_valid = (state == HOLD);
  assign in_fire   = in_valid && in_ready;
  assign count_inc = (&count) ? count : count + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ACC:     if (in_fire && in_last) next_state = HOLD;
      HOLD:    if (out_ready && !(in_fire && in_last)) next_state = ACC;
      default: next_state = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else if (in_fire) begin
      if (in_last) begin
        out_data  <= sum;
        out_count <= count_inc;
        acc       <= '0;
        count     <= '0;
      end else begin
        acc   <= sum;
        count <= count_inc;
      end
    end
  end

endmodule

// File: doc/float_accumulator.md
FLOAT_ACCUMULATOR -- requirements
Module: float_accumulator

Interface
REQ-001 Parameter EXP_WIDTH, default 8, SHALL set the exponent field width of all float ports.
REQ-002 Parameter SFD_WIDTH, default 23, SHALL set the stored significand field width of all float ports.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the element-counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL indicate in_data/in_last are valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts input this cycle.
REQ-008 in_data  input  EXP_WIDTH+SFD_WIDTH+1  SHALL carry the operand float {sign, exp, sfd}.
REQ-009 in_last  input  1  SHALL mark the final element of a vector.
REQ-010 out_valid  output  1  SHALL indicate out_data/out_count hold a completed sum.
REQ-011 out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-012 out_data  output  EXP_WIDTH+SFD_WIDTH+1  SHALL carry the vector sum.
REQ-013 out_count  output  CNT_WIDTH  SHALL carry the number of elements summed.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 The block SHALL have two states: ACC (accumulating) and HOLD (result pending).
REQ-016 In ACC, in_ready SHALL be 1; in HOLD, in_ready SHALL equal out_ready.
REQ-017 On each input transfer, the accumulator register SHALL load sum(acc, in_data) computed by the float adder, one element per cycle, no bubbles.
REQ-018 The sum SHALL use round-to-nearest-even, flush subnormals to zero, produce +inf/-inf on overflow, and produce NaN {0, all-ones exp, sfd=1} for any NaN operand or opposite infinities.
REQ-019 On an input transfer with in_last=1: out_data SHALL load the sum, out_count SHALL load count+1 (saturated), acc SHALL reset to +0, count to 0, state SHALL go to HOLD; out_valid asserts the following cycle (latency 1 from last accept).
REQ-020 In HOLD with out_ready=1 and no last-input transfer, state SHALL return to ACC and out_valid deassert next cycle.
REQ-021 In HOLD with out_ready=1 and simultaneous input transfer, the output transfer SHALL complete and the input SHALL be accumulated in the same cycle; if that input has in_last=1, a new result SHALL load and state stays HOLD.
REQ-022 out_data and out_count SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 count SHALL saturate at 2^CNT_WIDTH-1 and not wrap.
REQ-024 A NaN or infinity in acc SHALL persist until in_last clears the accumulator.
REQ-025 Inputs SHALL be ignored when in_valid=0 regardless of in_last.

Reset
REQ-026 On rst: state=ACC, acc=+0 (all zeros), count=0, out_valid=0, out_data=0, out_count=0.
REQ-027 Reset mid-vector SHALL discard partial sum with no output; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 A shared package float_pkg SHALL hold the state enum type and default EXP_WIDTH/SFD_WIDTH constants.
REQ-029 The combinational add SHALL be one instance of sub-module float_adder_norm (inputs acc, in_data); no other sub-modules.

Verification
REQ-030 Vector 0x3F800000, 0x40000000, 0x40400000(last), out_ready=1 -> out_data=0x40C00000 (6.0), out_count=3, out_valid one cycle after last accept.
REQ-031 Single element 0xC0490FDB with in_last -> out_data=0xC0490FDB, out_count=1.
REQ-032 0x7F800000 then 0xFF800000(last) -> out_data=0x7F800001; next vector 0x3F800000(last) -> 0x3F800000.
REQ-033 0x7F7FFFFF, 0x7F7FFFFF(last) -> out_data=0x7F800000.
REQ-034 Result pending with out_ready=0 for 5 cycles -> in_ready=0, out_data stable; then out_ready=1 with in_valid=1, in_last=1, 0x40000000 -> first result consumed, next out_data=0x40000000, out_valid stays 1.
REQ-035 rst asserted after two accepted elements -> out_valid=0, next vector 0x3F800000(last) yields 0x3F800000, out_count=1.
